// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer: pulses pll_rst, waits for lock, qualifies lock stability, then releases sys_rst.
// Optional macro PLL_LOCK_SUPERVISOR_LOSS_CNT_EN adds a saturating loss-of-lock counter output.
module pll_lock_supervisor #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3,
  parameter int SYNC_STAGES   = 2,
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic          refclk,
  input  logic          rst,
  input  logic          locked,
  input  logic          relock_req,
  output logic          pll_rst,
  output logic          sys_rst,
  output logic          ready,
  output logic          fail,
  output logic [RW-1:0] retry_cnt,
  output logic [2:0]    state
`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
  ,
  output logic [7:0]    loss_count
`endif
);

  localparam int CMAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CMAX   = (CMAX_A > STABLE_CYCLES) ? CMAX_A : STABLE_CYCLES;
  localparam int CW     = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [2:0] {
    S_PLLRST = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  state_t              state_q, state_n;
  logic [CW-1:0]       cnt_q, cnt_n;
  logic [RW-1:0]       retry_n;
  logic [SYNC_STAGES-1:0] locked_sync;
  logic                locked_s;

  assign locked_s = locked_sync[SYNC_STAGES-1];
  assign state    = state_q;

  // Lock synchronizer
  always_ff @(posedge refclk) begin
    if (rst) begin
      locked_sync <= '0;
    end else begin
      locked_sync <= {locked_sync[SYNC_STAGES-2:0], locked};
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    retry_n = retry_cnt;
    case (state_q)
      S_PLLRST: begin
        if (cnt_q == CW'(RST_CYCLES - 1)) begin
          state_n = S_WAIT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      S_WAIT, S_STABLE: begin
        // A timeout in WAIT and a lock drop in STABLE share the retry decision.
        if ((state_q == S_WAIT) ? (!locked_s && cnt_q == CW'(LOCK_TIMEOUT - 1)) : !locked_s) begin
          cnt_n = '0;
          if (retry_cnt == RW'(MAX_RETRIES)) begin
            state_n = S_FAIL;
          end else begin
            state_n = S_PLLRST;
            retry_n = retry_cnt + RW'(1);
          end
        end else if (state_q == S_WAIT) begin
          if (locked_s) begin
            state_n = S_STABLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_q + CW'(1);
          end
        end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
          state_n = S_RUN;
          cnt_n   = '0;
          retry_n = '0;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      S_RUN: begin
        if (!locked_s || relock_req) begin
          state_n = S_PLLRST;
          cnt_n   = '0;
          retry_n = '0;
        end
      end
      S_FAIL: begin
        if (relock_req) begin
          state_n = S_PLLRST;
          cnt_n   = '0;
          retry_n = '0;
        end
      end
      default: begin
        state_n = S_PLLRST;
        cnt_n   = '0;
        retry_n = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they move with state
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= S_PLLRST;
      cnt_q     <= '0;
      retry_cnt <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      retry_cnt <= retry_n;
      pll_rst   <= (state_n == S_PLLRST);
      sys_rst   <= (state_n != S_RUN);
      ready     <= (state_n == S_RUN);
      fail      <= (state_n == S_FAIL);
    end
  end

`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
  logic loss_inc;

  // Any RUN exit with lock low counts, even if relock_req arrived together.
  assign loss_inc = (state_q == S_RUN) && !locked_s;

  always_ff @(posedge refclk) begin
    if (rst) begin
      loss_count <= '0;
    end else if (loss_inc && loss_count != 8'hFF) begin
      loss_count <= loss_count + 8'd1;
    end
  end
`endif

endmodule
